// File: rtl/fifo_casc_pkg.sv
// Shared types and constants for the two-source FIFO cascade arbiter.
package fifo_casc_pkg;

    localparam int DW_DEF = 36;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_A = 2'd1,
        BURST_B = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_cascade_arb_skid.sv
// Two-entry skid FIFO with a registered head; push and pop may coincide.
module skid_buf2 #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] e0_q, e1_q;
    logic [1:0]   occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) e0_q <= din;
                    else               e1_q <= din;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    // occupancy is unchanged; only the entries shift
                    if (occ_q == 2'd1) begin
                        e0_q <= din;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = e0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_cascade_arb.sv
// Round-robin burst arbiter merging two standard-mode FIFOs into one sink.
module fifo_cascade_arb
    import fifo_casc_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic             int_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             empty_a,
    input  logic [DW-1:0]    dout_a,
    output logic             rd_en_a,
    input  logic             empty_b,
    input  logic [DW-1:0]    dout_b,
    output logic             rd_en_b,
    input  logic             full_1,
    output logic             wr_en_1,
    output logic [DW-1:0]    din_1,
    output logic             wr_src,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    state_e           state_q;
    logic             rr_q;
    logic [BW-1:0]    bcnt_q;
    logic             infl_q;
    logic             infl_src_q;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

    logic [DW:0] head;
    logic [DW:0] cap;
    logic [1:0]  occ;
    logic [2:0]  pend;
    logic        pop, credit, in_burst, leave, rd;
    logic        cur_src, cur_empty, oth_empty;

    assign pop       = (occ != 2'd0) & ~full_1;
    // words that would sit in the skid after this cycle without a new read
    assign pend      = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    assign credit    = (pend <= 3'd1);
    assign in_burst  = (state_q != IDLE);
    assign cur_src   = (state_q == BURST_B) ? SRC_B : SRC_A;
    assign cur_empty = (cur_src == SRC_B) ? empty_b : empty_a;
    assign oth_empty = (cur_src == SRC_B) ? empty_a : empty_b;
    assign leave     = in_burst & (~en | cur_empty | (bcnt_q == BMAX));
    assign rd        = in_burst & ~leave & credit;

    assign rd_en_a = rd & (cur_src == SRC_A);
    assign rd_en_b = rd & (cur_src == SRC_B);
    assign cap     = {infl_src_q, (infl_src_q == SRC_B) ? dout_b : dout_a};

    skid_buf2 #(.W(DW + 1)) u_skid (
        .clk   (int_clk),
        .rst_n (rst_n),
        .push  (infl_q),
        .pop   (pop),
        .din   (cap),
        .head  (head),
        .occ   (occ)
    );

    assign wr_en_1 = pop;
    assign din_1   = head[DW-1:0];
    assign wr_src  = head[DW];
    assign grant   = {state_q == BURST_B, state_q == BURST_A};
    assign busy    = in_burst | infl_q | (occ != 2'd0);
    assign cnt_a   = cnt_a_q;
    assign cnt_b   = cnt_b_q;

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= SRC_A;
            bcnt_q     <= '0;
            infl_q     <= 1'b0;
            infl_src_q <= SRC_A;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
        end else begin
            infl_q <= rd;
            if (rd) infl_src_q <= cur_src;
            if (pop) begin
                if (wr_src == SRC_B) cnt_b_q <= cnt_b_q + CNT_W'(1);
                else                 cnt_a_q <= cnt_a_q + CNT_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    bcnt_q <= '0;
                    if (en & ~empty_a & ((rr_q == SRC_A) | empty_b))
                        state_q <= BURST_A;
                    else if (en & ~empty_b)
                        state_q <= BURST_B;
                end
                BURST_A, BURST_B: begin
                    if (leave) begin
                        rr_q   <= ~cur_src;
                        bcnt_q <= '0;
                        if (en & ~oth_empty)
                            state_q <= (cur_src == SRC_B) ? BURST_A : BURST_B;
                        else if (en & ~cur_empty)
                            state_q <= state_q;
                        else
                            state_q <= IDLE;
                    end else if (rd) begin
                        bcnt_q <= bcnt_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_cascade_arb.sv
// Directed bench: behavioural source/sink FIFO models around fifo_cascade_arb.
module tb_fifo_cascade_arb;

    localparam int DW = 36;
    localparam int CW = 16;

    logic          int_clk = 1'b0;
    logic          rst_n, en, empty_a, empty_b, full_1;
    logic [DW-1:0] dout_a = '0, dout_b = '0, din_1;
    logic          rd_en_a, rd_en_b, wr_en_1, wr_src, busy;
    logic [1:0]    grant;
    logic [CW-1:0] cnt_a, cnt_b;

    always #5 int_clk = ~int_clk;

    fifo_cascade_arb #(.DW(DW), .MAX_BURST(16), .CNT_W(CW)) dut (
        .int_clk (int_clk),
        .rst_n   (rst_n),
        .en      (en),
        .empty_a (empty_a),
        .dout_a  (dout_a),
        .rd_en_a (rd_en_a),
        .empty_b (empty_b),
        .dout_b  (dout_b),
        .rd_en_b (rd_en_b),
        .full_1  (full_1),
        .wr_en_1 (wr_en_1),
        .din_1   (din_1),
        .wr_src  (wr_src),
        .grant   (grant),
        .busy    (busy),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];
    int wa, wb;
    int ra = 0, rb = 0;
    logic clr;

    int cyc = 0;
    int nwr = 0, nrd = 0, first_rd = -1;
    int rd_full = 0, rd_both = 0, rd_empty = 0, wr_full = 0, max_out = 0;
    logic [DW-1:0] log_d [128];
    logic          log_s [128];
    int            log_c [128];
    logic          rd_s  [128];
    int            rd_c  [128];

    int vecs, errs;

    assign empty_a = (ra == wa);
    assign empty_b = (rb == wb);

    always @(posedge int_clk) begin : model
        int o;
        cyc <= cyc + 1;
        if (clr) begin
            ra <= 0; rb <= 0; nwr <= 0; nrd <= 0; first_rd <= -1;
            rd_full <= 0; rd_both <= 0; rd_empty <= 0;
            wr_full <= 0; max_out <= 0;
        end else begin
            if (rd_en_a) begin dout_a <= mem_a[ra]; ra <= ra + 1; end
            if (rd_en_b) begin dout_b <= mem_b[rb]; rb <= rb + 1; end
            if (rd_en_a || rd_en_b) begin
                rd_s[nrd] <= rd_en_b;
                rd_c[nrd] <= cyc;
                nrd <= nrd + 1;
                if (nrd == 0) first_rd <= cyc;
            end
            if (rd_en_a && rd_en_b) rd_both <= rd_both + 1;
            if ((rd_en_a && empty_a) || (rd_en_b && empty_b))
                rd_empty <= rd_empty + 1;
            if ((rd_en_a || rd_en_b) && full_1) rd_full <= rd_full + 1;
            if (wr_en_1 && full_1) wr_full <= wr_full + 1;
            if (wr_en_1) begin
                log_d[nwr] <= din_1;
                log_s[nwr] <= wr_src;
                log_c[nwr] <= cyc;
                nwr <= nwr + 1;
            end
            o = (nrd + int'(rd_en_a || rd_en_b)) - (nwr + int'(wr_en_1));
            if (o > max_out) max_out <= o;
        end
    end

    function automatic logic [DW-1:0] pat(input logic s, input int i);
        return {s ? 4'hB : 4'hA, i[31:0]};
    endfunction

    task automatic fill(input int na, input int nb);
        @(negedge int_clk);
        for (int i = 0; i < na; i++) mem_a[i] = pat(1'b0, i);
        for (int i = 0; i < nb; i++) mem_b[i] = pat(1'b1, i);
        wa = na;
        wb = nb;
        en = 1'b1;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        repeat (3) @(negedge int_clk);
        while (busy && k < lim) begin
            @(negedge int_clk);
            k++;
        end
        vecs++;
        if (busy) begin
            errs++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, want 0", busy, lim);
        end
    endtask

    task automatic do_reset();
        @(negedge int_clk);
        rst_n = 1'b0; clr = 1'b1; en = 1'b0; full_1 = 1'b0; wa = 0; wb = 0;
        #1;
        vecs++;
        if ({rd_en_a, rd_en_b, wr_en_1, wr_src, grant, busy} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {rd_en_a, rd_en_b, wr_en_1, wr_src, grant, busy});
        end
        vecs++;
        if (din_1 !== '0) begin
            errs++;
            $display("FAIL reset_din: got %h want 0", din_1);
        end
        vecs++;
        if (cnt_a !== '0 || cnt_b !== '0) begin
            errs++;
            $display("FAIL reset_cnt: got a=%0d b=%0d want 0 0", cnt_a, cnt_b);
        end
        @(negedge int_clk);
        @(negedge int_clk);
        rst_n = 1'b1;
        @(negedge int_clk);
        clr = 1'b0;
    endtask

    task automatic test_single_a();
        int bad, g, w;
        do_reset();
        fill(40, 0);
        wait_idle(300);
        vecs++;
        if (nwr !== 40) begin
            errs++; $display("FAIL single_nwr: got %0d want 40", nwr);
        end
        bad = 0;
        for (int i = 0; i < 40; i++)
            if (log_d[i] !== pat(1'b0, i) || log_s[i] !== 1'b0) bad++;
        vecs++;
        if (bad != 0) begin
            errs++; $display("FAIL single_data: %0d bad words, want 0", bad);
        end
        vecs++;
        if (log_c[0] - first_rd !== 2) begin
            errs++;
            $display("FAIL single_latency: got %0d want 2", log_c[0] - first_rd);
        end
        bad = 0;
        for (int i = 1; i < 40; i++) begin
            g = rd_c[i] - rd_c[i-1];
            w = (i == 16 || i == 32) ? 2 : 1;
            if (g != w) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++; $display("FAIL single_bursts: %0d bad read gaps, want 0", bad);
        end
        vecs++;
        if (cnt_a !== 16'd40 || cnt_b !== 16'd0) begin
            errs++; $display("FAIL single_cnt: got a=%0d b=%0d want 40 0", cnt_a, cnt_b);
        end
        vecs++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            errs++; $display("FAIL single_end: got grant=%b busy=%b want 00 0", grant, busy);
        end
    endtask

    task automatic test_two_sources();
        int bad, ka, kb;
        logic ws;
        do_reset();
        fill(20, 20);
        wait_idle(300);
        vecs++;
        if (nrd !== 40 || nwr !== 40) begin
            errs++; $display("FAIL two_counts: got rd=%0d wr=%0d want 40 40", nrd, nwr);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            ws = (i >= 16 && i < 32) || (i >= 36);
            if (rd_s[i] !== ws) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++; $display("FAIL two_grant_seq: %0d reads from wrong source, want 0", bad);
        end
        bad = 0; ka = 0; kb = 0;
        for (int i = 0; i < 40; i++) begin
            if (log_s[i] !== rd_s[i]) bad++;
            if (log_s[i] === 1'b1) begin
                if (log_d[i] !== pat(1'b1, kb)) bad++;
                kb++;
            end else begin
                if (log_d[i] !== pat(1'b0, ka)) bad++;
                ka++;
            end
        end
        vecs++;
        if (bad != 0) begin
            errs++; $display("FAIL two_order: %0d misordered words, want 0", bad);
        end
        vecs++;
        if (rd_both !== 0) begin
            errs++; $display("FAIL two_dual_rd: got %0d cycles want 0", rd_both);
        end
        vecs++;
        if (cnt_a !== 16'd20 || cnt_b !== 16'd20) begin
            errs++; $display("FAIL two_cnt: got a=%0d b=%0d want 20 20", cnt_a, cnt_b);
        end
    endtask

    task automatic test_stall();
        int k, n0, kk, bad;
        do_reset();
        fill(30, 0);
        k = 0;
        while (nwr < 5 && k < 100) begin
            @(negedge int_clk);
            k++;
        end
        n0 = nwr;
        full_1 = 1'b1;
        repeat (5) @(negedge int_clk);
        kk = nwr;
        full_1 = 1'b0;
        wait_idle(300);
        vecs++;
        if (nwr !== 30) begin
            errs++; $display("FAIL stall_nwr: got %0d want 30", nwr);
        end
        bad = 0;
        for (int i = 0; i < 30; i++)
            if (log_d[i] !== pat(1'b0, i) || log_s[i] !== 1'b0) bad++;
        vecs++;
        if (bad != 0) begin
            errs++; $display("FAIL stall_data: %0d bad words, want 0", bad);
        end
        vecs++;
        if (rd_full !== 0 || wr_full !== 0 || kk !== n0) begin
            errs++;
            $display("FAIL stall_activity: got rd=%0d wr=%0d held=%0d want 0 0 %0d",
                     rd_full, wr_full, kk, n0);
        end
        vecs++;
        if (max_out !== 2) begin
            errs++; $display("FAIL stall_buffered: got %0d want 2", max_out);
        end
        vecs++;
        if (log_c[kk+1] - log_c[kk] !== 1 || log_c[kk+2] - log_c[kk+1] !== 1) begin
            errs++;
            $display("FAIL stall_resume: got gaps %0d %0d want 1 1",
                     log_c[kk+1] - log_c[kk], log_c[kk+2] - log_c[kk+1]);
        end
    endtask

    task automatic test_en_off();
        int k, bad;
        do_reset();
        fill(20, 0);
        k = 0;
        while (nrd < 5 && k < 100) begin
            @(negedge int_clk);
            k++;
        end
        en = 1'b0;
        #1;
        vecs++;
        if (busy !== 1'b1) begin
            errs++; $display("FAIL enoff_busy_hold: got %b want 1", busy);
        end
        wait_idle(100);
        vecs++;
        if (nrd !== 5 || nwr !== 5 || cnt_a !== 16'd5) begin
            errs++;
            $display("FAIL enoff_counts: got rd=%0d wr=%0d cnt=%0d want 5 5 5", nrd, nwr, cnt_a);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (log_d[i] !== pat(1'b0, i)) bad++;
        vecs++;
        if (bad != 0 || grant !== 2'b00) begin
            errs++; $display("FAIL enoff_end: bad=%0d grant=%b want 0 00", bad, grant);
        end
    endtask

    task automatic test_switch_empty();
        int bad, ka, kb;
        do_reset();
        fill(6, 10);
        wait_idle(200);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_s[i] !== (i >= 6)) bad++;
        vecs++;
        if (nrd !== 16 || bad != 0) begin
            errs++; $display("FAIL switch_seq: got rd=%0d bad=%0d want 16 0", nrd, bad);
        end
        vecs++;
        if (rd_c[6] - rd_c[5] !== 2) begin
            errs++; $display("FAIL switch_bubble: got %0d want 2", rd_c[6] - rd_c[5]);
        end
        vecs++;
        if (rd_empty !== 0) begin
            errs++; $display("FAIL switch_rd_empty: got %0d want 0", rd_empty);
        end
        bad = 0; ka = 0; kb = 0;
        for (int i = 0; i < 16; i++) begin
            if (log_s[i] === 1'b1) begin
                if (log_d[i] !== pat(1'b1, kb)) bad++;
                kb++;
            end else begin
                if (log_d[i] !== pat(1'b0, ka)) bad++;
                ka++;
            end
        end
        vecs++;
        if (bad != 0 || cnt_a !== 16'd6 || cnt_b !== 16'd10) begin
            errs++;
            $display("FAIL switch_data: bad=%0d a=%0d b=%0d want 0 6 10", bad, cnt_a, cnt_b);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        full_1 = 1'b1;
        fill(20, 0);
        repeat (6) @(negedge int_clk);
        vecs++;
        if (nrd !== 2 || nwr !== 0) begin
            errs++; $display("FAIL rstmid_fill: got rd=%0d wr=%0d want 2 0", nrd, nwr);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({rd_en_a, rd_en_b, wr_en_1, wr_src, grant, busy, din_1, cnt_a, cnt_b} !== '0) begin
            errs++;
            $display("FAIL rstmid_async: got ctl=%b din=%h a=%0d b=%0d want all 0",
                     {rd_en_a, rd_en_b, wr_en_1, wr_src, grant, busy}, din_1, cnt_a, cnt_b);
        end
        en = 1'b0;
        full_1 = 1'b0;
        repeat (2) @(negedge int_clk);
        n0 = nwr;
        rst_n = 1'b1;
        repeat (8) @(negedge int_clk);
        vecs++;
        if (nwr !== n0 || cnt_a !== '0 || cnt_b !== '0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_after: got wr=%0d a=%0d b=%0d busy=%b want %0d 0 0 0",
                     nwr, cnt_a, cnt_b, busy, n0);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b1; en = 1'b0; full_1 = 1'b0;
        wa = 0; wb = 0; vecs = 0; errs = 0;
        do_reset();
        test_single_a();
        test_two_sources();
        test_stall();
        test_en_off();
        test_switch_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
